mem_arbiter: RTL and testbench

- Shares the single byte-wide external RAM port between two requesters: instruction fetch (IF, 32-bit reads only) and the memory stage (MEM, byte/half/word reads and writes).
- Serialises each access into byte transfers and assembles or disassembles 32-bit words little-endian.
- Returns one-cycle done pulses that the pipeline uses to release its stalls.
- Sits between pc_reg/if_id and mem on the core side and the RAM on the other, replacing the direct rom_addr_o/rom_data_i path.

---
 rtl/mem_arbiter_pkg.sv | 34 +++
 rtl/mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings for the byte-serial memory arbiter.
//   BYTE_W          width of one RAM transfer
//   SIZE_B/H/W      mem_size encodings (2'b11 also means word)
//   state_e         arbiter FSM states
//   gnt_e           which requester owns the current access
//   size_to_nbytes  mem_size -> number of byte transfers (1, 2 or 4)
package mem_arbiter_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } gnt_e;

  function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between instruction fetch (IF)
// and the memory stage (MEM). Each access is serialised into byte transfers;
// words are assembled/disassembled little-endian. MEM has priority.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   if_req/if_addr/if_abort  fetch request (32-bit read), flush cancel
//   if_done/if_rdata         one-cycle done pulse with fetched word
//   mem_req/mem_we/mem_addr/mem_size/mem_wdata
//                            data request, byte/half/word read or write
//   mem_done/mem_rdata       one-cycle done pulse with zero-extended data
//   ram_addr/ram_dout/ram_wr byte RAM address, write byte, write strobe
//   ram_din                  byte RAM read data, one cycle after ram_addr
//   busy                     high whenever the arbiter is not idle
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned WORD_W = 32   // only 32 is supported
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_abort,
  output logic              if_done,
  output logic [WORD_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_size,
  input  logic [WORD_W-1:0] mem_wdata,
  output logic              mem_done,
  output logic [WORD_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              ram_wr,
  output logic              busy
);

  state_e            state_q, state_d;
  gnt_e              gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] res_q, res_d;
  logic [WORD_W-1:0] if_rdata_q, if_rdata_d;
  logic [WORD_W-1:0] mem_rdata_q, mem_rdata_d;

  logic       abort_hit;
  logic       last_cnt;
  logic [2:0] cap_idx;
  logic       in_access;
  logic       addr_phase;
  logic       done_if;
  logic       done_mem;

  // Abort only matters while IF owns the port; the caller gates on state.
  assign abort_hit = (gnt_q == GNT_IF) && if_abort;

  // Reads need one extra cycle to collect the byte of the last address.
  assign last_cnt  = we_q ? (cnt_q == nbytes_q - 3'd1) : (cnt_q == nbytes_q);
  assign cap_idx   = cnt_q - 3'd1;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    nbytes_d    = nbytes_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          gnt_d    = GNT_MEM;
          addr_d   = mem_addr;
          we_d     = mem_we;
          nbytes_d = size_to_nbytes(mem_size);
          wdata_d  = mem_wdata;
          cnt_d    = '0;
          res_d    = '0;
          state_d  = ST_ACCESS;
        end else if (if_req) begin
          gnt_d    = GNT_IF;
          addr_d   = if_addr;
          we_d     = 1'b0;
          nbytes_d = size_to_nbytes(SIZE_W);
          wdata_d  = '0;
          cnt_d    = '0;
          res_d    = '0;
          state_d  = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (abort_hit) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          // Byte for the address driven last cycle is on ram_din now.
          if (!we_q && (cnt_q != 3'd0)) begin
            res_d[{cap_idx[1:0], 3'b000} +: BYTE_W] = ram_din;
          end
          if (last_cnt) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (!abort_hit) begin
          if (gnt_q == GNT_IF) begin
            if_rdata_d = res_q;
          end else if (!we_q) begin
            mem_rdata_d = res_q;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= GNT_IF;
      addr_q      <= '0;
      we_q        <= 1'b0;
      nbytes_q    <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      nbytes_q    <= nbytes_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign in_access  = (state_q == ST_ACCESS);
  assign addr_phase = in_access && (cnt_q < nbytes_q);

  assign ram_addr = addr_phase ? (addr_q + ADDR_W'(cnt_q)) : '0;
  assign ram_wr   = in_access && we_q;
  assign ram_dout = (in_access && we_q) ? wdata_q[{cnt_q[1:0], 3'b000} +: BYTE_W] : '0;

  // A flush arriving during DONE must still kill the IF pulse that cycle,
  // so if_done is gated by the live if_abort input.
  assign done_if  = (state_q == ST_DONE) && (gnt_q == GNT_IF) && !if_abort;
  assign done_mem = (state_q == ST_DONE) && (gnt_q == GNT_MEM);

  assign if_done  = done_if;
  assign mem_done = done_mem;

  // The assembled word is shown during the done cycle and committed to the
  // hold register at its end, so an aborted DONE leaves if_rdata untouched.
  assign if_rdata  = done_if ? res_q : if_rdata_q;
  assign mem_rdata = (done_mem && !we_q) ? res_q : mem_rdata_q;

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_abort;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [31:0] ram_addr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
  logic        ram_wr;
  logic        busy;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned wr_count = 0;

  logic [31:0] exp_if_rdata  = '0;
  logic [31:0] exp_mem_rdata = '0;

  logic [7:0] ram_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  mem_arbiter #(.ADDR_W(32), .WORD_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_abort (if_abort),
    .if_done  (if_done),
    .if_rdata (if_rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_size (mem_size),
    .mem_wdata(mem_wdata),
    .mem_done (mem_done),
    .mem_rdata(mem_rdata),
    .ram_addr (ram_addr),
    .ram_dout (ram_dout),
    .ram_din  (ram_din),
    .ram_wr   (ram_wr),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram_mem.exists(a)) return ram_mem[a];
    return init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_byte(a);
  endfunction

  // Byte RAM: data for the address presented in one cycle appears the next.
  initial ram_din = 8'h00;
  always @(posedge clk) begin
    ram_din <= ram_rd(ram_addr);
    if (ram_wr) begin
      ram_mem[ram_addr] = ram_dout;
      wr_count++;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    ram_mem[a] = b;
    ref_mem[a] = b;
  endtask

  function automatic int unsigned nbytes_of(input logic [1:0] size);
    if (size == 2'b00) return 1;
    if (size == 2'b01) return 2;
    return 4;
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ram_wr"},    64'(ram_wr), 64'd0);
    check_eq({tag, "_ram_addr"},  64'(ram_addr), 64'd0);
    check_eq({tag, "_ram_dout"},  64'(ram_dout), 64'd0);
    check_eq({tag, "_busy"},      64'(busy), 64'd0);
    check_eq({tag, "_if_done"},   64'(if_done), 64'd0);
    check_eq({tag, "_mem_done"},  64'(mem_done), 64'd0);
    check_eq({tag, "_if_rdata"},  64'(if_rdata), 64'd0);
    check_eq({tag, "_mem_rdata"}, 64'(mem_rdata), 64'd0);
  endtask

  // One complete access, cycle 0 being the IDLE cycle in which the request
  // is sampled. Transaction-level expectations: N byte cycles at addr+k,
  // then (reads) one collect cycle, then the done cycle.
  task automatic run_txn(input bit is_mem, input bit we, input logic [31:0] addr,
                         input logic [1:0] size, input logic [31:0] wdata,
                         input bit if_pend, input logic [31:0] pend_addr,
                         input bit start_now);
    int unsigned n;
    int unsigned d;
    bit          wr;
    logic [31:0] exp_res;
    logic [31:0] exp_a;
    logic [7:0]  exp_b;
    bit          exp_wr;
    n  = is_mem ? nbytes_of(size) : 4;
    wr = is_mem && we;
    d  = wr ? n + 1 : n + 2;
    exp_res = '0;
    if (!wr) begin
      for (int unsigned k = 0; k < n; k++) begin
        exp_a   = addr + k;
        exp_res = exp_res | (32'(ref_rd(exp_a)) << (8 * k));
      end
    end
    if (!start_now) @(negedge clk);
    check_eq("idle_busy", 64'(busy), 64'd0);
    if (is_mem) begin
      mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_size = size; mem_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    if (if_pend) begin
      if_req = 1'b1; if_addr = pend_addr;
    end
    for (int unsigned c = 1; c <= d; c++) begin
      @(negedge clk);
      exp_wr = wr && (c <= n);
      exp_a  = (c <= n) ? addr + (c - 1) : 32'd0;
      exp_b  = exp_wr ? 8'(wdata >> (8 * (c - 1))) : 8'd0;
      if (c == d && !wr) begin
        if (is_mem) exp_mem_rdata = exp_res;
        else        exp_if_rdata  = exp_res;
      end
      check_eq("ram_addr", 64'(ram_addr), 64'(exp_a));
      check_eq("ram_wr",   64'(ram_wr), 64'(exp_wr));
      check_eq("ram_dout", 64'(ram_dout), 64'(exp_b));
      check_eq("busy",     64'(busy), 64'd1);
      check_eq("if_done",  64'(if_done), 64'(!is_mem && c == d));
      check_eq("mem_done", 64'(mem_done), 64'(is_mem && c == d));
      check_eq("if_rdata", 64'(if_rdata), 64'(exp_if_rdata));
      check_eq("mem_rdata", 64'(mem_rdata), 64'(exp_mem_rdata));
      if (is_mem) if_abort = 1'($urandom_range(0, 1));
      if (c == d) begin
        if_abort = 1'b0;
        if (is_mem) begin
          mem_req = 1'b0; mem_we = 1'b0;
        end else begin
          if_req = 1'b0;
        end
        if (wr) begin
          for (int unsigned k = 0; k < n; k++) begin
            exp_a = addr + k;
            ref_mem[exp_a] = 8'(wdata >> (8 * k));
          end
        end
      end
    end
  endtask

  // Fetch that is flushed in cycle a; a MEM read is raised alongside the
  // flush and must be granted in the IDLE cycle that follows. With late=1
  // the flush rises just after the edge that starts cycle a.
  task automatic run_abort(input logic [31:0] addr, input int unsigned a, input bit late,
                           input logic [1:0] psize, input logic [31:0] paddr);
    logic [31:0] exp_a;
    @(negedge clk);
    check_eq("ab_idle_busy", 64'(busy), 64'd0);
    if_req = 1'b1; if_addr = addr;
    for (int unsigned c = 1; c <= a; c++) begin
      if (late && c == a) begin
        @(posedge clk);
        #1;
        if_abort = 1'b1; if_req = 1'b0;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = paddr; mem_size = psize;
      end
      @(negedge clk);
      exp_a = (c <= 4) ? addr + (c - 1) : 32'd0;
      check_eq("ab_ram_addr", 64'(ram_addr), 64'(exp_a));
      check_eq("ab_ram_wr",   64'(ram_wr), 64'd0);
      check_eq("ab_busy",     64'(busy), 64'd1);
      check_eq("ab_if_done",  64'(if_done), 64'd0);
      check_eq("ab_mem_done", 64'(mem_done), 64'd0);
      check_eq("ab_if_rdata", 64'(if_rdata), 64'(exp_if_rdata));
      if (!late && c == a) begin
        if_abort = 1'b1; if_req = 1'b0;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = paddr; mem_size = psize;
      end
    end
    @(negedge clk);
    check_eq("ab_after_busy",     64'(busy), 64'd0);
    check_eq("ab_after_if_done",  64'(if_done), 64'd0);
    check_eq("ab_after_ram_addr", 64'(ram_addr), 64'd0);
    check_eq("ab_after_if_rdata", 64'(if_rdata), 64'(exp_if_rdata));
    if_abort = 1'b0;
  endtask

  logic [31:0] pool [3] = '{32'h0000_0300, 32'hFFFF_FFF8, 32'h0000_0100};

  initial begin
    int unsigned snap;
    int unsigned kind;
    logic [31:0] ra;
    logic [31:0] pa;
    logic [1:0]  rs;
    logic [31:0] rw;

    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; if_abort = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_size = '0; mem_wdata = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h10); poke(32'h103, 8'h00);
    poke(32'h200, 8'hAB);
    poke(32'hFFFF_FFFF, 8'h34); poke(32'h0, 8'h12);

    // Word fetch.
    run_txn(0, 0, 32'h100, 2'b10, '0, 0, '0, 0);
    check_eq("fetch_word", 64'(if_rdata), 64'h0010_0513);

    // Simultaneous requests: MEM first, pending IF granted right after.
    run_txn(1, 0, 32'h200, 2'b00, '0, 1, 32'h100, 0);
    check_eq("simul_mem_byte", 64'(mem_rdata), 64'h0000_00AB);
    run_txn(0, 0, 32'h100, 2'b10, '0, 0, '0, 0);

    // Word write then read back.
    run_txn(1, 1, 32'h300, 2'b10, 32'hDEAD_BEEF, 0, '0, 0);
    run_txn(1, 0, 32'h300, 2'b11, '0, 0, '0, 0);
    check_eq("write_readback", 64'(mem_rdata), 64'hDEAD_BEEF);

    // Half read wrapping past the top of the address space.
    run_txn(1, 0, 32'hFFFF_FFFF, 2'b01, '0, 0, '0, 0);
    check_eq("half_wrap", 64'(mem_rdata), 64'h0000_1234);

    // Flush in cycle 3 with a pending word read.
    run_abort(32'h100, 3, 0, 2'b10, 32'h300);
    run_txn(1, 0, 32'h300, 2'b10, '0, 0, '0, 1);
    // Flush arriving during the done cycle.
    run_abort(32'h104, 6, 1, 2'b00, 32'h200);
    run_txn(1, 0, 32'h200, 2'b00, '0, 0, '0, 1);
    check_eq("abort_if_hold", 64'(if_rdata), 64'h0010_0513);

    // Byte and half writes, read back as a word.
    run_txn(1, 1, 32'h304, 2'b00, 32'h1234_5677, 0, '0, 0);
    run_txn(1, 1, 32'h306, 2'b01, 32'hFFFF_A55A, 0, '0, 0);
    run_txn(1, 0, 32'h304, 2'b10, '0, 0, '0, 0);
    check_eq("bh_write_word", 64'(mem_rdata), 64'hA55A_0B77 & 64'hFFFF_00FF | 64'(ref_rd(32'h305)) << 8);

    // Reset during cycle 2 of a word write.
    @(negedge clk);
    check_eq("rst_idle", 64'(busy), 64'd0);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h300; mem_size = 2'b10; mem_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    check_eq("rst_c1_wr",   64'(ram_wr), 64'd1);
    check_eq("rst_c1_dout", 64'(ram_dout), 64'h0D);
    check_eq("rst_c1_addr", 64'(ram_addr), 64'h300);
    @(negedge clk);
    check_eq("rst_c2_dout", 64'(ram_dout), 64'hF0);
    snap = wr_count;
    rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
    #1;
    check_all_zero("midrst");
    ref_mem[32'h300] = 8'h0D;
    exp_if_rdata  = '0;
    exp_mem_rdata = '0;
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_hold_wr",   64'(ram_wr), 64'd0);
      check_eq("rst_hold_done", 64'(mem_done), 64'd0);
      check_eq("rst_hold_busy", 64'(busy), 64'd0);
    end
    rst = 1'b0;
    check_eq("rst_no_writes", 64'(wr_count), 64'(snap));
    run_txn(1, 0, 32'h300, 2'b10, '0, 0, '0, 0);
    check_eq("rst_partial", 64'(mem_rdata), 64'hDEAD_BE0D);

    // Randomized mix of fetches, reads, writes and contended requests.
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      ra = pool[$urandom_range(0, 2)] + $urandom_range(0, 7);
      pa = pool[$urandom_range(0, 2)] + $urandom_range(0, 7);
      rs = 2'($urandom_range(0, 3));
      rw = $urandom();
      case (kind)
        0: run_txn(0, 0, ra, 2'b10, '0, 0, '0, 0);
        1: run_txn(1, 0, ra, rs, '0, 0, '0, 0);
        2: run_txn(1, 1, ra, rs, rw, 0, '0, 0);
        default: begin
          run_txn(1, 1'($urandom_range(0, 1)), ra, rs, rw, 1, pa, 0);
          run_txn(0, 0, pa, 2'b10, '0, 0, '0, 0);
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
